// File: rtl/systolic_array.sv
// Weight-stationary NxN systolic multiply array: ans = a x W, one vector per cycle, latency 2N-1 edges.
// Optional a_vld/ans_vld qualifier pipeline is enabled by defining SYSTOLIC_VALID_EN.
module systolic_array #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*DW-1:0] a,
    input  logic [N*DW-1:0] b,
    input  logic            switch,
`ifdef SYSTOLIC_VALID_EN
    input  logic            a_vld,
    output logic            ans_vld,
`endif
    output logic [N*DW-1:0] ans
);

    logic [DW-1:0] w       [N][N];
    logic [DW-1:0] row_in  [N];
    logic [DW-1:0] psum    [N][N];
    logic [DW-1:0] act     [N][N-1];
    logic [DW-1:0] col_out [N];

    // Weights enter at row 0 and ripple downward while loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w[r][c] <= '0;
                end
            end
        end else if (!switch) begin
            for (int c = 0; c < N; c++) begin
                w[0][c] <= b[c*DW +: DW];
            end
            for (int r = 1; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w[r][c] <= w[r-1][c];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign row_in[i] = a[i*DW +: DW];
        end else begin : g_delay
            logic [DW-1:0] sr [i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < i; j++) begin
                        sr[j] <= '0;
                    end
                end else begin
                    sr[0] <= a[i*DW +: DW];
                    for (int j = 1; j < i; j++) begin
                        sr[j] <= sr[j-1];
                    end
                end
            end

            assign row_in[i] = sr[i-1];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_pe
            logic [DW-1:0] act_in;
            logic [DW-1:0] psum_in;
            logic [DW-1:0] psum_q;

            if (c == 0) begin : g_act_edge
                assign act_in = row_in[r];
            end else begin : g_act_chain
                assign act_in = act[r][c-1];
            end

            if (r == 0) begin : g_psum_top
                assign psum_in = '0;
            end else begin : g_psum_chain
                assign psum_in = psum[r-1][c];
            end

            // Products and sums wrap modulo 2^DW by truncation to the register width.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    psum_q <= '0;
                end else begin
                    psum_q <= psum_in + act_in * w[r][c];
                end
            end

            assign psum[r][c] = psum_q;

            if (c < N-1) begin : g_act_reg
                logic [DW-1:0] act_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        act_q <= '0;
                    end else begin
                        act_q <= act_in;
                    end
                end

                assign act[r][c] = act_q;
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_deskew
        localparam int L = N - 1 - c;

        if (L == 0) begin : g_direct
            assign col_out[c] = psum[N-1][c];
        end else begin : g_delay
            logic [DW-1:0] sr [L];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < L; j++) begin
                        sr[j] <= '0;
                    end
                end else begin
                    sr[0] <= psum[N-1][c];
                    for (int j = 1; j < L; j++) begin
                        sr[j] <= sr[j-1];
                    end
                end
            end

            assign col_out[c] = sr[L-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                ans[c*DW +: DW] <= col_out[c];
            end
        end
    end

`ifdef SYSTOLIC_VALID_EN
    logic [2*N-2:0] vld_sr;

    // Valid tracks the data through the same number of register stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            ans_vld <= 1'b0;
        end else begin
            vld_sr  <= {vld_sr[2*N-3:0], a_vld};
            ans_vld <= vld_sr[2*N-2];
        end
    end
`endif

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench for systolic_array: a reference model predicts every ans vector from the
// history of inputs and weights; a separate monitor pops and compares each cycle.
module tb_systolic_array;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int LAT  = 2*N - 1;
    localparam int MAXE = 4096;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    logic            switch;
    logic [N*DW-1:0] ans;
`ifdef SYSTOLIC_VALID_EN
    logic            a_vld;
    logic            ans_vld;
`endif

    int checks = 0;
    int passes = 0;
    int e = 0;
    int rst_edge = 0;
    int kd;

    logic [N*DW-1:0] exp_q [$];
    logic [DW-1:0]   wm     [N][N];
    logic [DW-1:0]   hist_a [MAXE][N];
    logic [DW-1:0]   hist_w [MAXE][N][N];
    logic [N*DW-1:0] model_ev;
    logic [DW-1:0]   model_sum;
    int              model_k;

    systolic_array #(.N(N), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .switch (switch),
`ifdef SYSTOLIC_VALID_EN
        .a_vld  (a_vld),
        .ans_vld(ans_vld),
`endif
        .ans    (ans)
    );

    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] vec(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                            input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [N*DW-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [N*DW-1:0] expv);
        checks++;
        if (ans === expv) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at edge %0d: ans=%h expected=%h", name, e, ans, expv);
        end
    endtask

    task automatic applyStimulus(input logic [N*DW-1:0] av, input logic [N*DW-1:0] bv, input logic sw);
        @(negedge clk);
        a      = av;
        b      = bv;
        switch = sw;
    endtask

    task automatic waitEdge(input int target);
        int guard = 0;
        while (e < target && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (e < target) begin
            checks++;
            $display("[TB] FAIL wait_edge: reached edge %0d, required %0d", e, target);
        end
    endtask

    // Reference model: ans after edge k+LAT is sum over r of a_k[r] * W[r][c] as seen at edge k+r+c.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        wm[r][c] = '0;
                    end
                end
                rst_edge = e;
                exp_q.delete();
            end else begin
                e++;
                if (e >= MAXE) begin
                    $display("[TB] FAIL edge_budget: edge %0d, limit %0d", e, MAXE);
                    $fatal(1, "[TB] edge budget exhausted");
                end
                for (int r = 0; r < N; r++) begin
                    hist_a[e][r] = a[r*DW +: DW];
                    for (int c = 0; c < N; c++) begin
                        hist_w[e][r][c] = wm[r][c];
                    end
                end
                if (!switch) begin
                    for (int r = N-1; r > 0; r--) begin
                        for (int c = 0; c < N; c++) begin
                            wm[r][c] = wm[r-1][c];
                        end
                    end
                    for (int c = 0; c < N; c++) begin
                        wm[0][c] = b[c*DW +: DW];
                    end
                end
                model_k  = e - LAT;
                model_ev = '0;
                if (model_k > rst_edge) begin
                    for (int c = 0; c < N; c++) begin
                        model_sum = '0;
                        for (int r = 0; r < N; r++) begin
                            model_sum = model_sum + hist_a[model_k][r] * hist_w[model_k+r+c][r][c];
                        end
                        model_ev[c*DW +: DW] = model_sum;
                    end
                end
                exp_q.push_back(model_ev);
            end
        end
    end

    // Monitor: one expected vector is consumed per clock while out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("reset_hold", '0);
            end else if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL scoreboard_empty: ans=%h with no expected entry", ans);
            end else begin
                checkOutput("stream", exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        switch = 1'b0;
`ifdef SYSTOLIC_VALID_EN
        a_vld  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (LAT + 1) applyStimulus('0, '0, 1'b1);

        // Anti-diagonal weights: output is the reversed activation vector.
        applyStimulus('0, vec(1, 0, 0, 0), 1'b0);
        applyStimulus('0, vec(0, 1, 0, 0), 1'b0);
        applyStimulus('0, vec(0, 0, 1, 0), 1'b0);
        applyStimulus('0, vec(0, 0, 0, 1), 1'b0);
        applyStimulus(vec(1, 0, 0, 1), '0, 1'b1);
        kd = e + 1;
        applyStimulus(vec(0, 1, 1, 1), '0, 1'b1);
        applyStimulus(vec(0, 1, 1, 0), '0, 1'b1);
        applyStimulus(vec(0, 1, 0, 1), '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        waitEdge(kd + LAT);
        checkOutput("antidiag_0", vec(1, 0, 0, 1));
        @(negedge clk);
        checkOutput("antidiag_1", vec(1, 1, 1, 0));
        repeat (LAT) applyStimulus('0, '0, 1'b1);

        // General matrix, rows 0..3 = 1..16.
        applyStimulus('0, vec(13, 14, 15, 16), 1'b0);
        applyStimulus('0, vec(9, 10, 11, 12), 1'b0);
        applyStimulus('0, vec(5, 6, 7, 8), 1'b0);
        applyStimulus('0, vec(1, 2, 3, 4), 1'b0);
        applyStimulus(vec(1, 1, 1, 1), '0, 1'b1);
        kd = e + 1;
        applyStimulus(vec(1, 0, 0, 0), '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        waitEdge(kd + LAT);
        checkOutput("matrix_ones", vec(28, 32, 36, 40));
        @(negedge clk);
        checkOutput("matrix_unit", vec(1, 2, 3, 4));

        // Modulo wrap on a single large weight.
        repeat (3) applyStimulus('0, '0, 1'b0);
        applyStimulus('0, vec(32'hFFFF_FFFF, 0, 0, 0), 1'b0);
        applyStimulus(vec(2, 0, 0, 0), '0, 1'b1);
        kd = e + 1;
        applyStimulus('0, '0, 1'b1);
        waitEdge(kd + LAT);
        checkOutput("wrap", vec(32'hFFFF_FFFE, 0, 0, 0));

        // Random weights, then frozen streaming with b toggling.
        repeat (N) applyStimulus('0, rnd_vec(), 1'b0);
        repeat (40) applyStimulus(rnd_vec(), rnd_vec(), 1'b1);

        // Weight changes while vectors are in flight.
        repeat (30) applyStimulus(rnd_vec(), rnd_vec(), 1'($urandom_range(0, 1)));

        // Reset in the middle of a stream; nothing is reloaded afterwards.
        repeat (N) applyStimulus('0, rnd_vec(), 1'b0);
        repeat (5) applyStimulus(rnd_vec(), rnd_vec(), 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async", '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) applyStimulus(rnd_vec(), rnd_vec(), 1'b1);
        checkOutput("post_reset_zero", '0);

        repeat (LAT + 2) applyStimulus('0, '0, 1'b1);
        @(negedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- Weight-stationary N×N systolic multiply array: a weight matrix is shifted in row-by-row, frozen, then one activation vector per cycle is streamed through.
- Produces one output vector per cycle, ans = a × W, with fixed pipeline latency.
- Sits as the matrix-multiply compute core between operand buffers and the result path.
- Includes internal input skew and output deskew, so callers see aligned vectors only.

Parameters:
- N, 4, array dimension (rows = columns); vector length of a, b, ans.
- DW, 32, element width in bits for weights, activations and partial sums.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  N*DW  activation vector; element i at bits [i*DW +: DW]; element i feeds array row i.
- b  input  N*DW  weight-load vector; element c at bits [c*DW +: DW]; element c feeds column c.
- switch  input  1  0 = weight-load mode (weights shift each cycle); 1 = compute mode (weights frozen).
- ans  output  N*DW  result vector; element c at bits [c*DW +: DW].

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all weight registers, skew/deskew registers, activation and partial-sum pipeline registers, and ans go to 0 immediately; they stay 0 until the first rising edge after deassertion.
- Weight load (switch=0 at a rising edge): W row 0 ← b; W row r ← W row r-1 for r = 1..N-1.
  - After N load edges, the last loaded vector is row 0 and the first loaded vector is row N-1.
- Weight freeze (switch=1): W holds its value; b is ignored.
- Compute pipeline runs every cycle regardless of switch, always using the current W.
  - Changing W while vectors are in flight mixes weights. This is legal, and the result is defined by the cycle-level model below.
- Row i activation is delayed i cycles by the input skew. Activations then move one PE right per cycle.
- PE[r][c] each cycle:
  - psum_out ← psum_in + act × W[r][c], registered.
  - act passes right, registered.
  - Row 0 psum_in = 0.
- Column c bottom psum is delayed (N-1-c) cycles by the output deskew, so every element of a given vector emerges together.
- Result: a vector sampled at edge k appears on ans after edge k+2N-1 (7 for N=4).
  - ans[c] = Σ_{r=0..N-1} a[r]·W[r][c].
  - Throughput: one vector per cycle, no stalls.
- Arithmetic: unsigned, modulo 2^DW. Products and sums are truncated to the low DW bits, with no saturation or overflow flag. Low bits equal the two's-complement signed result.
- ans is registered and holds its value between updates. There are no combinational paths from inputs to ans.
- Reset mid-operation clears all in-flight data. Outputs are 0 until new vectors propagate, and W must be reloaded.

Optional Feature:
- Macro SYSTOLIC_VALID_EN.
- When defined:
  - Adds input a_vld (1 bit) and output ans_vld (1 bit).
  - a_vld is pipelined alongside the data; ans_vld = a_vld sampled 2N-1 edges earlier.
  - ans_vld resets to 0.
  - ans is still updated every cycle; ans_vld only qualifies it.
- When undefined: neither port exists, and ans is qualified by latency alone.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> ans=0 immediately; still 0 for 7 edges after release with a=0.
- Anti-diagonal load:
  - Stimulus: switch=0 for 4 edges with b = (1,0,0,0), (0,1,0,0), (0,0,1,0), (0,0,0,1), written [b0,b1,b2,b3]; then switch=1.
  - Stream a = [1,0,0,1], [0,1,1,1], [0,1,1,0], [0,1,0,1] on consecutive edges.
  - Response: ans = reversed a, e.g. [1,0,0,1], [1,1,1,0], [0,1,1,0], [1,0,1,0], each 7 edges after its input.
- General matrix: W rows r=0..3 = [1,2,3,4], [5,6,7,8], [9,10,11,12], [13,14,15,16]; a = [1,1,1,1] -> ans = [28,32,36,40]; a = [1,0,0,0] on the next edge -> ans = [1,2,3,4] one cycle later.
- Wrap-around: W[0][0] = 0xFFFFFFFF, rest 0; a = [2,0,0,0] -> ans[0] = 0xFFFFFFFE.
- Freeze: with switch=1, toggle b randomly while streaming -> results unchanged versus fixed W.
- Reset mid-stream: pulse rst_n low during streaming -> ans=0; after release, with no reload, all outputs 0 because W=0.
